// File: rtl/chiptop_tap_pkg.sv
`default_nettype none
// chiptop_tap_pkg: TAP state encoding, instruction codes and data-register selection. Rev 1.0.
// CHIPTOP_TAP_IDCODE_EN makes IDCODE the reset instruction and selects the ID register.
package chiptop_tap_pkg;

  localparam int IR_WIDTH = 4;

  typedef enum logic [3:0] {
    TLR    = 4'hF,
    RTI    = 4'hC,
    SEL_DR = 4'h7,
    CAP_DR = 4'h6,
    SH_DR  = 4'h2,
    EX1_DR = 4'h1,
    PAU_DR = 4'h3,
    EX2_DR = 4'h0,
    UPD_DR = 4'h5,
    SEL_IR = 4'h4,
    CAP_IR = 4'hE,
    SH_IR  = 4'hA,
    EX1_IR = 4'h9,
    PAU_IR = 4'hB,
    EX2_IR = 4'h8,
    UPD_IR = 4'hD
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_BSR    = 2'd1,
    DR_IDCODE = 2'd2
  } dr_sel_e;

  localparam logic [IR_WIDTH-1:0] INSTR_BYPASS         = 4'h0;
  localparam logic [IR_WIDTH-1:0] INSTR_SAMPLE_PRELOAD = 4'h1;
  localparam logic [IR_WIDTH-1:0] INSTR_EXTEST         = 4'h2;
  localparam logic [IR_WIDTH-1:0] INSTR_IDCODE         = 4'h4;
  localparam logic [IR_WIDTH-1:0] INSTR_CLAMP          = 4'hC;

`ifdef CHIPTOP_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = INSTR_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = INSTR_BYPASS;
`endif

  function automatic dr_sel_e dr_select(input logic [IR_WIDTH-1:0] instr);
    case (instr)
      INSTR_SAMPLE_PRELOAD, INSTR_EXTEST: return DR_BSR;
`ifdef CHIPTOP_TAP_IDCODE_EN
      INSTR_IDCODE: return DR_IDCODE;
`else
      INSTR_IDCODE: return DR_BYPASS;
`endif
      INSTR_BYPASS, INSTR_CLAMP: return DR_BYPASS;
      default: return DR_BYPASS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/chiptop_tap_fsm.sv
`default_nettype none
// chiptop_tap_fsm: 16-state IEEE 1149.1 TAP state register and TMS next-state logic. Rev 1.0.
module chiptop_tap_fsm
  import chiptop_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_e state
);

  tap_state_e next_state;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) state <= TLR;
    else         state <= next_state;
  end

  always_comb begin
    next_state = TLR;
    case (state)
      TLR:    next_state = tms ? TLR    : RTI;
      RTI:    next_state = tms ? SEL_DR : RTI;
      SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms ? UPD_DR : PAU_DR;
      PAU_DR: next_state = tms ? EX2_DR : PAU_DR;
      EX2_DR: next_state = tms ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR: next_state = tms ? TLR    : CAP_IR;
      CAP_IR: next_state = tms ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms ? UPD_IR : PAU_IR;
      PAU_IR: next_state = tms ? EX2_IR : PAU_IR;
      EX2_IR: next_state = tms ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/chiptop_tap_controller.sv
`default_nettype none
// chiptop_tap_controller: TAP controller with IR, bypass/ID data registers, BSR strobes and tdo mux. Rev 1.0.
// Optional 32-bit ID register is built when CHIPTOP_TAP_IDCODE_EN is defined.
module chiptop_tap_controller
  import chiptop_tap_pkg::*;
#(
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE = 4'b0101
`ifdef CHIPTOP_TAP_IDCODE_EN
  , parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
`endif
) (
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_en,
  output logic       CHIPTOP_instructions_3_,
  output logic       CHIPTOP_instructions_2_,
  output logic       CHIPTOP_instructions_1_,
  output logic       CHIPTOP_instructions_0_,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  input  logic       bsr_tdo,
  output logic [3:0] tap_state
);

  tap_state_e          state;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_par;
  logic                bypass_bit;
  logic                tdo_next;
  dr_sel_e             dr_sel;

  chiptop_tap_fsm u_fsm (
    .tck    (tck),
    .trst_n (trst_n),
    .tms    (tms),
    .state  (state)
  );

  assign dr_sel = dr_select(ir_par);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      ir_shift   <= IR_CAPTURE;
      bypass_bit <= 1'b0;
    end else begin
      case (state)
        CAP_IR:  ir_shift   <= IR_CAPTURE;
        SH_IR:   ir_shift   <= {tdi, ir_shift[IR_WIDTH-1:1]};
        CAP_DR:  bypass_bit <= 1'b0;
        SH_DR:   bypass_bit <= tdi;
        default: ;
      endcase
    end
  end

`ifdef CHIPTOP_TAP_IDCODE_EN
  logic [31:0] idcode_sr;

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      idcode_sr <= IDCODE_VALUE;
    end else if (dr_sel == DR_IDCODE) begin
      if (state == CAP_DR)     idcode_sr <= IDCODE_VALUE;
      else if (state == SH_DR) idcode_sr <= {tdi, idcode_sr[31:1]};
    end
  end
`endif

  always_comb begin
    tdo_next = 1'b0;
    if (state == SH_IR) begin
      tdo_next = ir_shift[0];
    end else if (state == SH_DR) begin
      case (dr_sel)
        DR_BSR:    tdo_next = bsr_tdo;
`ifdef CHIPTOP_TAP_IDCODE_EN
        DR_IDCODE: tdo_next = idcode_sr[0];
`endif
        default:   tdo_next = bypass_bit;
      endcase
    end
  end

  // Falling-edge stage: tdo launches half a cycle ahead of the next capture edge,
  // and the instruction changes only once the update state has settled.
  always_ff @(negedge tck or negedge trst_n) begin
    if (!trst_n) begin
      tdo    <= 1'b0;
      tdo_en <= 1'b0;
      ir_par <= RESET_INSTR;
    end else begin
      tdo    <= tdo_next;
      tdo_en <= (state == SH_DR) || (state == SH_IR);
      if (state == TLR)         ir_par <= RESET_INSTR;
      else if (state == UPD_IR) ir_par <= ir_shift;
    end
  end

  assign capture_dr = (state == CAP_DR) && (dr_sel == DR_BSR);
  assign shift_dr   = (state == SH_DR)  && (dr_sel == DR_BSR);
  assign update_dr  = (state == UPD_DR) && (dr_sel == DR_BSR);

  assign {CHIPTOP_instructions_3_, CHIPTOP_instructions_2_,
          CHIPTOP_instructions_1_, CHIPTOP_instructions_0_} = ir_par;

  assign tap_state = state;

endmodule
`default_nettype wire

// File: tb/tb_chiptop_tap_controller.sv
`default_nettype none
// tb_chiptop_tap_controller: directed and random TMS/TDI walks checked against a queue-based TAP model.
module tb_chiptop_tap_controller;
  import chiptop_tap_pkg::*;

  localparam logic [3:0] IR_CAP = 4'b0101;
`ifdef CHIPTOP_TAP_IDCODE_EN
  localparam logic [31:0] ID_VAL    = 32'h1234_5679;
  localparam logic [3:0]  RST_INSTR = 4'h4;
`else
  localparam logic [3:0]  RST_INSTR = 4'h0;
`endif

  logic       tck = 1'b0;
  logic       trst_n = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       bsr_tdo = 1'b0;
  logic       tdo, tdo_en, capture_dr, shift_dr, update_dr;
  logic [3:0] instr;
  logic [3:0] tap_state;

  chiptop_tap_controller #(
    .IR_CAPTURE (IR_CAP)
`ifdef CHIPTOP_TAP_IDCODE_EN
    , .IDCODE_VALUE (ID_VAL)
`endif
  ) dut (
    .tck                     (tck),
    .trst_n                  (trst_n),
    .tms                     (tms),
    .tdi                     (tdi),
    .tdo                     (tdo),
    .tdo_en                  (tdo_en),
    .CHIPTOP_instructions_3_ (instr[3]),
    .CHIPTOP_instructions_2_ (instr[2]),
    .CHIPTOP_instructions_1_ (instr[1]),
    .CHIPTOP_instructions_0_ (instr[0]),
    .capture_dr              (capture_dr),
    .shift_dr                (shift_dr),
    .update_dr               (update_dr),
    .bsr_tdo                 (bsr_tdo),
    .tap_state               (tap_state)
  );

  always #5 tck = ~tck;

  int vectors = 0;
  int miscompares = 0;
  bit exp_q[$];

  // Reference model: TMS graph as a table, registers as bit queues (front = bit nearest tdo).
  tap_state_e nxt[16][2];
  tap_state_e m_state;
  bit         m_ir[$];
  bit         m_dr[$];
  logic [3:0] m_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_to(input tap_state_e s, input tap_state_e on0, input tap_state_e on1);
    nxt[s][0] = on0;
    nxt[s][1] = on1;
  endtask

  task automatic build_graph();
    edge_to(TLR,    RTI,    TLR);
    edge_to(RTI,    RTI,    SEL_DR);
    edge_to(SEL_DR, CAP_DR, SEL_IR);
    edge_to(CAP_DR, SH_DR,  EX1_DR);
    edge_to(SH_DR,  SH_DR,  EX1_DR);
    edge_to(EX1_DR, PAU_DR, UPD_DR);
    edge_to(PAU_DR, PAU_DR, EX2_DR);
    edge_to(EX2_DR, SH_DR,  UPD_DR);
    edge_to(UPD_DR, RTI,    SEL_DR);
    edge_to(SEL_IR, CAP_IR, TLR);
    edge_to(CAP_IR, SH_IR,  EX1_IR);
    edge_to(SH_IR,  SH_IR,  EX1_IR);
    edge_to(EX1_IR, PAU_IR, UPD_IR);
    edge_to(PAU_IR, PAU_IR, EX2_IR);
    edge_to(EX2_IR, SH_IR,  UPD_IR);
    edge_to(UPD_IR, RTI,    SEL_DR);
  endtask

  function automatic bit sel_bsr(input logic [3:0] i);
    return (i == 4'h1) || (i == 4'h2);
  endfunction

  function automatic bit sel_id(input logic [3:0] i);
`ifdef CHIPTOP_TAP_IDCODE_EN
    return i == 4'h4;
`else
    return (i != i);
`endif
  endfunction

  task automatic load_ir_capture();
    m_ir.delete();
    for (int i = 0; i < 4; i++) m_ir.push_back(IR_CAP[i]);
  endtask

  task automatic model_reset();
    m_state = TLR;
    load_ir_capture();
    m_instr = RST_INSTR;
    m_dr.delete();
    m_dr.push_back(1'b0);
    exp_q.delete();
  endtask

  // One TCK cycle: check outputs launched by the falling edge, then drive and advance the model.
  task automatic step(input bit t, input bit d);
    bit sh;
    @(negedge tck);
    #1;
    if (m_state == UPD_IR) for (int i = 0; i < 4; i++) m_instr[i] = m_ir[i];
    else if (m_state == TLR) m_instr = RST_INSTR;
    sh = (m_state == SH_DR) || (m_state == SH_IR);
    check("tap_state", tap_state, m_state);
    check("instructions", instr, m_instr);
    check("tdo_en", tdo_en, sh);
    check("strobes", {capture_dr, shift_dr, update_dr},
          sel_bsr(m_instr) ? {m_state == CAP_DR, m_state == SH_DR, m_state == UPD_DR} : 3'b000);
    if (!sh)                  check("tdo_idle", tdo, 1'b0);
    else if (m_state == SH_IR) exp_q.push_back(m_ir[0]);
    else                       exp_q.push_back(sel_bsr(m_instr) ? bsr_tdo : m_dr[0]);
    tms = t;
    tdi = d;
    bsr_tdo = 1'($urandom_range(0, 1));
    case (m_state)
      CAP_IR: load_ir_capture();
      SH_IR: begin void'(m_ir.pop_front()); m_ir.push_back(d); end
      CAP_DR: begin
        m_dr.delete();
`ifdef CHIPTOP_TAP_IDCODE_EN
        if (sel_id(m_instr)) for (int i = 0; i < 32; i++) m_dr.push_back(ID_VAL[i]);
        else m_dr.push_back(1'b0);
`else
        if (!sel_id(m_instr)) m_dr.push_back(1'b0);
`endif
      end
      SH_DR: begin void'(m_dr.pop_front()); m_dr.push_back(d); end
      default: ;
    endcase
    m_state = nxt[m_state][t];
  endtask

  task automatic async_reset();
    @(negedge tck);
    #2;
    trst_n = 1'b0;
    tms = 1'b1;
    #1;
    check("rst_state", tap_state, TLR);
    check("rst_instr", instr, RST_INSTR);
    check("rst_tdo_en", tdo_en, 1'b0);
    check("rst_tdo", tdo, 1'b0);
    check("rst_strobes", {capture_dr, shift_dr, update_dr}, 3'b000);
    model_reset();
    @(negedge tck);
    #2;
    trst_n = 1'b1;
  endtask

  // From RTI: load an instruction LSB-first, return to RTI.
  task automatic load_ir(input logic [3:0] v);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, v[i]);
    step(1, 0); step(0, 0);
  endtask

  // From RTI: capture, shift n bits (bits[0] first), update, return to RTI.
  task automatic scan_dr(input int n, input logic [31:0] bits);
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) step(i == n - 1, bits[i]);
    step(1, 0); step(0, 0);
  endtask

  always @(posedge tck) begin
    if (trst_n && tdo_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL tdo_unexpected: tdo_en high with no expected bit, tdo=%b at %0t", tdo, $time);
      end else begin
        check("tdo", tdo, exp_q.pop_front());
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    build_graph();
    model_reset();
    repeat (2) @(negedge tck);
    #1;
    check("por_state", tap_state, TLR);
    check("por_instr", instr, RST_INSTR);
    check("por_tdo_en", tdo_en, 1'b0);
    check("por_tdo", tdo, 1'b0);
    #1;
    trst_n = 1'b1;

    step(0, 0);
`ifdef CHIPTOP_TAP_IDCODE_EN
    scan_dr(32, 32'h0);
`endif
    load_ir(4'h2);
    check("ir_extest", instr, 4'h2);
    scan_dr(8, 32'hA5);
    load_ir(4'h0);
    scan_dr(4, 32'hD);
    load_ir(4'h4);
    scan_dr(6, 32'h2B);
    load_ir(4'hC);
    scan_dr(3, 32'h5);

    // Mid-shift asynchronous reset.
    load_ir(4'h1);
    step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
    async_reset();
    step(0, 0);

    // TMS reset from PAU_IR.
    step(1, 0); step(1, 0); step(0, 0); step(0, 1); step(1, 0); step(0, 0); step(0, 0);
    check("in_pause_ir", tap_state, PAU_IR);
    repeat (5) step(1, 0);
    @(posedge tck);
    #1;
    check("tms_reset", tap_state, TLR);
    step(0, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else step($urandom_range(0, 9) < 3, 1'($urandom_range(0, 1)));
    end
    repeat (6) step(1, 0);

    @(negedge tck);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
